// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit for the E stage: fixed-latency mult/multu/div/divu,
// mthi/mtlo writes, mfhi/mflo read mux, and a busy flag for the hazard unit.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  Multiop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hilo_out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    // state   | meaning
    // IDLE    | HI/LO settled; accepts start and mthi/mtlo
    // BUSY    | result held in pend_q, counting down to commit

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] prod_s, prod_u, arith_res;
    logic        signed_div, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, q_div, r_div;

    always_comb begin
        prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u = {32'b0, A} * {32'b0, B};

        // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of trapping.
        signed_div = ~Multiop[0];
        a_neg      = signed_div & A[31];
        b_neg      = signed_div & B[31];
        a_mag      = a_neg ? (32'd0 - A) : A;
        b_mag      = b_neg ? (32'd0 - B) : B;
        q_mag      = 32'd0;
        r_mag      = 32'd0;
        if (B != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        q_div = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        r_div = a_neg ? (32'd0 - r_mag) : r_mag;

        // Divide-by-zero re-commits the current HI/LO, which cannot change while BUSY.
        if (!Multiop[1]) begin
            arith_res = Multiop[0] ? prod_u : prod_s;
        end else if (B == 32'd0) begin
            arith_res = {hi_q, lo_q};
        end else begin
            arith_res = {r_div, q_div};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (Multiop[2]) begin
                    if (Multiop[1:0] == 2'b00) begin
                        hi_d = A;
                    end else if (Multiop[1:0] == 2'b01) begin
                        lo_d = A;
                    end
                end else if (start) begin
                    pend_d  = arith_res;
                    cnt_d   = Multiop[1] ? DIV_LOAD : MULT_LOAD;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    hi_d    = pend_q[63:32];
                    lo_d    = pend_q[31:0];
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            pend_q  <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        case (Multiop)
            3'b111:  hilo_out = hi_q;
            3'b110:  hilo_out = lo_q;
            default: hilo_out = 32'd0;
        endcase
    end

    assign busy = (state_q == ST_BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected results from a
// plain-arithmetic model; a negedge monitor checks latency and HI/LO at each commit.
module tb_mult_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  Multiop;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hilo_out;
    logic [31:0] HI;
    logic [31:0] LO;

    mult_div_unit #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .Multiop (Multiop),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .hilo_out(hilo_out),
        .HI      (HI),
        .LO      (LO)
    );

    typedef struct {
        logic [63:0] prev;
        logic [63:0] res;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] model;
    int          checks;
    int          failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] cur);
        int          ia, ib;
        longint      sa, sbv, q, r;
        logic [63:0] ua, ub;
        ia  = $signed(a);
        ib  = $signed(b);
        sa  = ia;
        sbv = ib;
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        case (op)
            3'd0: return sa * sbv;
            3'd1: return ua * ub;
            3'd2: begin
                if (b == 32'd0) return cur;
                q = sa / sbv;
                r = sa % sbv;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return cur;
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    // Monitor: busy run length and the committed HI/LO at busy fall.
    bit          in_op;
    int          cyc;
    exp_t        mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            in_op = 1'b0;
            cyc   = 0;
        end else if (busy) begin
            if (!in_op) begin
                in_op = 1'b1;
                cyc   = 0;
                if (exp_q.size() == 0) begin
                    chk("busy_without_cmd", 64'(busy), 64'd0);
                end
            end
            cyc++;
            if (exp_q.size() > 0) begin
                chk("hilo_hold_busy", {HI, LO}, exp_q[0].prev);
            end
        end else if (in_op) begin
            in_op = 1'b0;
            if (exp_q.size() == 0) begin
                chk("commit_without_cmd", 64'(1), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("busy_cycles", 64'(cyc), 64'(mon_e.lat));
                chk("commit_hilo", {HI, LO}, mon_e.res);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit wait_done);
        exp_t e;
        @(posedge clk);
        #1;
        start   = 1'b1;
        Multiop = op;
        A       = a;
        B       = b;
        e.prev  = model;
        e.res   = ref_op(op, a, b, model);
        e.lat   = op[1] ? DIV_N : MULT_N;
        exp_q.push_back(e);
        model   = e.res;
        @(posedge clk);
        #1;
        start   = 1'b0;
        Multiop = 3'b110;
        if (wait_done) wait_idle();
    endtask

    task automatic check_reads();
        Multiop = 3'b111;
        #1;
        chk("mfhi", 64'(hilo_out), 64'(model[63:32]));
        Multiop = 3'b110;
        #1;
        chk("mflo", 64'(hilo_out), 64'(model[31:0]));
        Multiop = 3'b000;
        #1;
        chk("hilo_out_other", 64'(hilo_out), 64'd0);
        Multiop = 3'b110;
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] ra, rb;
        int          sel;
        checks   = 0;
        failures = 0;
        model    = 64'd0;
        reset    = 1'b0;
        start    = 1'b0;
        Multiop  = 3'b111;
        A        = 32'd0;
        B        = 32'd0;
        #23;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hilo", {HI, LO}, 64'd0);
        chk("reset_mfhi", 64'(hilo_out), 64'd0);
        Multiop = 3'b110;
        @(posedge clk);
        #1;
        reset = 1'b1;

        issue(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b1);
        chk("mult_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
        chk("multu_big", {HI, LO}, 64'h0000_0001_FFFF_FFFE);
        check_reads();
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
        chk("div_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(3'd3, 32'd7, 32'd0, 1'b1);
        chk("divu_zero", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        chk("div_ovf", {HI, LO}, 64'h0000_0000_8000_0000);

        @(posedge clk);
        #1;
        Multiop = 3'b100;
        A       = 32'h1234_5678;
        @(posedge clk);
        #1;
        Multiop = 3'b110;
        model[63:32] = 32'h1234_5678;
        chk("mthi", 64'(HI), 64'h1234_5678);
        check_reads();

        issue(3'd0, 32'd3, 32'd4, 1'b0);
        Multiop = 3'b101;
        A       = 32'h0000_AAAA;
        @(posedge clk);
        #1;
        Multiop = 3'b110;
        wait_idle();
        chk("mtlo_ignored", 64'(LO), 64'd12);

        issue(3'd1, 32'd100, 32'd7, 1'b0);
        start   = 1'b1;
        Multiop = 3'b011;
        A       = 32'd99;
        B       = 32'd5;
        @(posedge clk);
        #1;
        start   = 1'b0;
        Multiop = 3'b110;
        wait_idle();
        chk("second_start_ignored", {HI, LO}, 64'd700);

        issue(3'd2, 32'd1000, 32'd3, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        model = 64'd0;
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_hilo", {HI, LO}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        issue(3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1);
        chk("mult_after_rst", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);

        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 3));
            sel = $urandom_range(0, 7);
            ra  = $urandom;
            rb  = $urandom;
            if (sel == 0) rb = 32'd0;
            if (sel == 1) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            if (sel == 2) rb = 32'($urandom_range(1, 15));
            if (sel == 3) ra = 32'($urandom_range(0, 20));
            issue(op, ra, rb, 1'b1);
            if ((i % 8) == 0) check_reads();
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Responder for the multiply/divide command interface driven by the decode controller via Multiop[2:0] and start.
- Executes mult, multu, div and divu with fixed multi-cycle latency.
- Holds the HI/LO registers, serves mthi/mtlo writes and mfhi/mflo reads, and raises busy so the hazard unit can stall later HI/LO-dependent instructions.
- Sits in the E stage beside the ALU; operands come from the forwarded rs/rt values.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (>=1).
- DIV_CYCLES, 10, busy duration for div/divu (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- start  input  1  1-cycle command strobe for mult/multu/div/divu.
- Multiop  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 mflo, 111 mfhi.
- A  input  32  rs operand.
- B  input  32  rt operand.
- busy  output  1  operation in flight.
- hilo_out  output  32  read data for mfhi/mflo.
- HI  output  32  current HI register.
- LO  output  32  current LO register.

Behaviour:
- Reset (reset==0, async):
  - HI=0, LO=0, busy=0, counter=0; state=IDLE.
  - Pending result and latched op are discarded.
- States: IDLE and BUSY.
  - Only 4-bit counter and 64-bit pending-result registers are added beyond HI/LO.
- IDLE with start==1 and Multiop in 000..011, sampled at edge T0:
  - Compute the 64-bit result into pending {hi,lo}.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to BUSY; busy=1 from T0.
- IDLE with start==1 and Multiop in 100..111: start is ignored; the Multiop meaning still applies.
- BUSY:
  - counter decrements each edge.
  - At the edge where counter goes 1->0, commit pending to HI/LO, drop busy to 0, return to IDLE.
  - busy is therefore high for exactly N cycles. New HI/LO is visible combinationally in cycle T0+N.
- start or mthi/mtlo while BUSY: ignored. No queueing; upstream must stall on (busy|start).
- mthi/mtlo (Multiop 100/101, start==0, IDLE):
  - Write A into HI/LO at the clock edge.
  - Held for every cycle Multiop is 100/101, so the controller must present it for one cycle per instruction.
- Arithmetic:
  - mult: signed 32x32 -> 64-bit product; {HI,LO}=product.
  - multu: the same operation, unsigned.
  - div: signed, truncates toward zero. LO=quotient, HI=remainder, remainder takes the dividend's sign.
  - divu: the same operation, unsigned.
  - Division by zero (B==0): busy still runs DIV_CYCLES; HI/LO are left unchanged at commit.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- hilo_out (combinational):
  - Multiop 111 -> HI.
  - Multiop 110 -> LO.
  - Otherwise 0.
  - Reflects committed registers only, never pending values.
- HI/LO outputs: always the committed registers.

Test Plan:
- Reset, then mult A=0xFFFFFFFF, B=2 with a 1-cycle start -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; HI/LO unchanged while busy.
- multu A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles; mfhi then gives hilo_out=0x00000001.
- div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 -> busy 10 cycles, HI/LO unchanged.
- mthi A=0x12345678 in IDLE -> HI=0x12345678 next edge. Issue mult, then mtlo A=0xAAAA during busy -> LO ignored and equals the mult result at commit.
- Second start asserted during BUSY with different operands -> ignored; result matches the first op; busy does not extend.
- Deassert reset (drive low) at the 3rd busy cycle of a div -> busy=0, HI=LO=0 immediately without waiting for a clock edge; after release the next mult completes normally.
